// File: rtl/blake2_g_sched.sv
`default_nettype none
// ===========================================================================
// blake2_g_sched : BLAKE2 compression scheduler that feeds an external G mixer
// Rev 1.0
// ===========================================================================
module blake2_g_sched #(
  parameter int W      = 32,
  parameter int ROUNDS = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [16*W-1:0] v_i,
  input  logic [16*W-1:0] m_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [16*W-1:0] v_o,
  output logic [W-1:0]    g_a_o,
  output logic [W-1:0]    g_b_o,
  output logic [W-1:0]    g_c_o,
  output logic [W-1:0]    g_d_o,
  output logic [W-1:0]    g_x_o,
  output logic [W-1:0]    g_y_o,
  input  logic [W-1:0]    g_a_i,
  input  logic [W-1:0]    g_b_i,
  input  logic [W-1:0]    g_c_i,
  input  logic [W-1:0]    g_d_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WB    = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] C_LAST_R = 4'(ROUNDS - 1);

  state_t       state_q, state_d;
  logic [3:0]   r_q, r_d;
  logic [2:0]   j_q, j_d;
  logic [W-1:0] v_q [16];
  logic [W-1:0] m_q [16];

  logic [3:0]   w_ia, w_ib, w_ic, w_id;
  logic [3:0]   w_rmod;
  logic [63:0]  w_row;
  logic [7:0]   w_pair;

  // One SIGMA row per permutation; entry 0 sits in the most significant nibble.
  function automatic logic [63:0] sigma_row(input logic [3:0] row);
    case (row)
      4'd0:    sigma_row = 64'h0123_4567_89AB_CDEF;
      4'd1:    sigma_row = 64'hEA48_9FD6_1C02_B753;
      4'd2:    sigma_row = 64'hB8C0_52FD_AE36_7194;
      4'd3:    sigma_row = 64'h7931_DCBE_265A_40F8;
      4'd4:    sigma_row = 64'h9057_24AF_E1BC_683D;
      4'd5:    sigma_row = 64'h2C6A_0B83_4D75_FE19;
      4'd6:    sigma_row = 64'hC51F_ED4A_0763_928B;
      4'd7:    sigma_row = 64'hDB7E_C139_50F4_862A;
      4'd8:    sigma_row = 64'h6FE9_B308_C2D7_14A5;
      4'd9:    sigma_row = 64'hA284_7615_FB9E_3CD0;
      default: sigma_row = 64'h0123_4567_89AB_CDEF;
    endcase
  endfunction

  // Column calls 0..3, then diagonal calls 4..7.
  always_comb begin
    w_ia = 4'd0;
    w_ib = 4'd4;
    w_ic = 4'd8;
    w_id = 4'd12;
    case (j_q)
      3'd0:    {w_ia, w_ib, w_ic, w_id} = {4'd0, 4'd4, 4'd8,  4'd12};
      3'd1:    {w_ia, w_ib, w_ic, w_id} = {4'd1, 4'd5, 4'd9,  4'd13};
      3'd2:    {w_ia, w_ib, w_ic, w_id} = {4'd2, 4'd6, 4'd10, 4'd14};
      3'd3:    {w_ia, w_ib, w_ic, w_id} = {4'd3, 4'd7, 4'd11, 4'd15};
      3'd4:    {w_ia, w_ib, w_ic, w_id} = {4'd0, 4'd5, 4'd10, 4'd15};
      3'd5:    {w_ia, w_ib, w_ic, w_id} = {4'd1, 4'd6, 4'd11, 4'd12};
      3'd6:    {w_ia, w_ib, w_ic, w_id} = {4'd2, 4'd7, 4'd8,  4'd13};
      default: {w_ia, w_ib, w_ic, w_id} = {4'd3, 4'd4, 4'd9,  4'd14};
    endcase
  end

  assign w_rmod = (r_q >= 4'd10) ? (r_q - 4'd10) : r_q;
  assign w_row  = sigma_row(w_rmod);
  assign w_pair = w_row[{3'd7 - j_q, 3'b000} +: 8];

  assign g_a_o = v_q[w_ia];
  assign g_b_o = v_q[w_ib];
  assign g_c_o = v_q[w_ic];
  assign g_d_o = v_q[w_id];
  assign g_x_o = m_q[w_pair[7:4]];
  assign g_y_o = m_q[w_pair[3:0]];

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    j_d     = j_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_ISSUE;
          r_d     = 4'd0;
          j_d     = 3'd0;
        end
      end
      S_ISSUE: state_d = S_WB;
      S_WB: begin
        j_d     = j_q + 3'd1;
        state_d = S_ISSUE;
        if (j_q == 3'd7) begin
          r_d = r_q + 4'd1;
          if (r_q == C_LAST_R) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= 4'd0;
      j_q     <= 3'd0;
      for (int i = 0; i < 16; i++) begin
        v_q[i] <= '0;
        m_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      j_q     <= j_d;
      if (state_q == S_IDLE && start_i) begin
        for (int i = 0; i < 16; i++) begin
          v_q[i] <= v_i[W*i +: W];
          m_q[i] <= m_i[W*i +: W];
        end
      end else if (state_q == S_WB) begin
        v_q[w_ia] <= g_a_i;
        v_q[w_ib] <= g_b_i;
        v_q[w_ic] <= g_c_i;
        v_q[w_id] <= g_d_i;
      end
    end
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_pack
    assign v_o[W*gi +: W] = v_q[gi];
  end

  assign busy_o = (state_q == S_ISSUE) || (state_q == S_WB);
  assign done_o = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_blake2_g_sched.sv
`default_nettype none
// tb_blake2_g_sched: vector table, RFC 7693 "abc", corner sequences and random
// runs against a BLAKE2s reference; instances with ROUNDS = 10, 12 and 1.
module tb_blake2_g_sched;
  localparam int W    = 32;
  localparam int VW   = 16 * W;
  localparam int NDUT = 3;

  localparam int IA [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  localparam int IB [8] = '{4, 5, 6, 7, 5, 6, 7, 4};
  localparam int IC [8] = '{8, 9, 10, 11, 10, 11, 8, 9};
  localparam int ID [8] = '{12, 13, 14, 15, 15, 12, 13, 14};
  localparam int SIG [10][16] = '{
    '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
    '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
    '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
    '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
    '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
    '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
    '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
    '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
    '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
    '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}
  };
  localparam logic [31:0] ABC_V [16] = '{
    32'h6B08E647, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
    32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19,
    32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
    32'h510E527C, 32'h9B05688C, 32'hE07C2654, 32'h5BE0CD19
  };
  localparam logic [31:0] ABC_H [8] = '{
    32'h8C5E8C50, 32'hE2147C32, 32'hA32BA7E1, 32'h2F45EB4E,
    32'h208B4537, 32'h293AD69E, 32'h4C9B994D, 32'h82596786
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [VW-1:0]   v_in, m_in;
  logic [NDUT-1:0] start, busy, done;
  logic [VW-1:0]   vo [NDUT];
  logic [W-1:0]    ga_o [NDUT], gb_o [NDUT], gc_o [NDUT], gd_o [NDUT], gx_o [NDUT], gy_o [NDUT];
  logic [W-1:0]    ga_i [NDUT], gb_i [NDUT], gc_i [NDUT], gd_i [NDUT];
  logic [W-1:0]    qa [NDUT], qb [NDUT], qc [NDUT], qd [NDUT], qx [NDUT], qy [NDUT];

  blake2_g_sched #(.W(W), .ROUNDS(10)) dut (
    .clk(clk), .rst(rst), .start_i(start[0]), .v_i(v_in), .m_i(m_in),
    .busy_o(busy[0]), .done_o(done[0]), .v_o(vo[0]),
    .g_a_o(ga_o[0]), .g_b_o(gb_o[0]), .g_c_o(gc_o[0]), .g_d_o(gd_o[0]),
    .g_x_o(gx_o[0]), .g_y_o(gy_o[0]),
    .g_a_i(ga_i[0]), .g_b_i(gb_i[0]), .g_c_i(gc_i[0]), .g_d_i(gd_i[0]));

  blake2_g_sched #(.W(W), .ROUNDS(12)) dut12 (
    .clk(clk), .rst(rst), .start_i(start[1]), .v_i(v_in), .m_i(m_in),
    .busy_o(busy[1]), .done_o(done[1]), .v_o(vo[1]),
    .g_a_o(ga_o[1]), .g_b_o(gb_o[1]), .g_c_o(gc_o[1]), .g_d_o(gd_o[1]),
    .g_x_o(gx_o[1]), .g_y_o(gy_o[1]),
    .g_a_i(ga_i[1]), .g_b_i(gb_i[1]), .g_c_i(gc_i[1]), .g_d_i(gd_i[1]));

  blake2_g_sched #(.W(W), .ROUNDS(1)) dut1 (
    .clk(clk), .rst(rst), .start_i(start[2]), .v_i(v_in), .m_i(m_in),
    .busy_o(busy[2]), .done_o(done[2]), .v_o(vo[2]),
    .g_a_o(ga_o[2]), .g_b_o(gb_o[2]), .g_c_o(gc_o[2]), .g_d_o(gd_o[2]),
    .g_x_o(gx_o[2]), .g_y_o(gy_o[2]),
    .g_a_i(ga_i[2]), .g_b_i(gb_i[2]), .g_c_i(gc_i[2]), .g_d_i(gd_i[2]));

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int n);
    return (x >> n) | (x << (W - n));
  endfunction

  function automatic logic [4*W-1:0] g_fn(input logic [W-1:0] a_in, b_in, c_in, d_in, x, y);
    logic [W-1:0] a, b, c, d;
    a = a_in; b = b_in; c = c_in; d = d_in;
    a = a + b + x; d = rotr(d ^ a, 16);
    c = c + d;     b = rotr(b ^ c, 12);
    a = a + b + y; d = rotr(d ^ a, 8);
    c = c + d;     b = rotr(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  // External G mixer: operands captured on each edge, results combinational.
  always @(posedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      qa[k] <= ga_o[k]; qb[k] <= gb_o[k]; qc[k] <= gc_o[k];
      qd[k] <= gd_o[k]; qx[k] <= gx_o[k]; qy[k] <= gy_o[k];
    end
  end

  always_comb begin
    for (int k = 0; k < NDUT; k++) begin
      {ga_i[k], gb_i[k], gc_i[k], gd_i[k]} = g_fn(qa[k], qb[k], qc[k], qd[k], qx[k], qy[k]);
    end
  end

  // Working vector after the first ncalls G calls of the compression.
  function automatic logic [VW-1:0] ref_comp(input logic [VW-1:0] vin, min, input int ncalls);
    logic [W-1:0]   v [16];
    logic [W-1:0]   m [16];
    logic [4*W-1:0] g;
    logic [VW-1:0]  res;
    for (int i = 0; i < 16; i++) begin
      v[i] = vin[W*i +: W];
      m[i] = min[W*i +: W];
    end
    for (int k = 0; k < ncalls; k++) begin
      int j, s;
      j = k % 8;
      s = (k / 8) % 10;
      g = g_fn(v[IA[j]], v[IB[j]], v[IC[j]], v[ID[j]], m[SIG[s][2*j]], m[SIG[s][2*j+1]]);
      {v[IA[j]], v[IB[j]], v[IC[j]], v[ID[j]]} = g;
    end
    for (int i = 0; i < 16; i++) res[W*i +: W] = v[i];
    return res;
  endfunction

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] r;
    for (int i = 0; i < 16; i++) r[W*i +: W] = $urandom;
    return r;
  endfunction

  function automatic int rounds_of(input int d);
    return (d == 0) ? 10 : ((d == 1) ? 12 : 1);
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns in cycle 1 (start accepted on the edge just passed).
  task automatic start_dut(input int d);
    start[d] = 1'b1;
    step();
    start[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, output int cyc);
    cyc = 1;
    while (!done[d] && cyc < 400) begin
      step();
      cyc++;
    end
  endtask

  task automatic run_to_done(input int d, input string name);
    logic [VW-1:0] exp;
    int cyc;
    exp = ref_comp(v_in, m_in, 8 * rounds_of(d));
    start_dut(d);
    v_in = rnd_vec();
    m_in = rnd_vec();
    wait_done(d, cyc);
    chk({name, "_done_cycle"}, cyc, 1 + 16 * rounds_of(d));
    chk({name, "_v_o"}, vo[d], exp);
    step();
    chk({name, "_idle_busy"}, busy[d], 1'b0);
  endtask

  typedef struct {
    int d;
    int r;
    int j;
    int ex;
    int ey;
  } probe_t;

  probe_t tbl [9];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [VW-1:0] exp, vm, v_start;
    int cyc, nd, dc, tgt;

    tbl[0] = '{0, 0, 0, 0, 1};
    tbl[1] = '{0, 1, 0, 14, 10};
    tbl[2] = '{0, 0, 7, 14, 15};
    tbl[3] = '{0, 1, 7, 5, 3};
    tbl[4] = '{0, 9, 3, 1, 5};
    tbl[5] = '{0, 4, 2, 2, 4};
    tbl[6] = '{1, 10, 0, 0, 1};
    tbl[7] = '{1, 11, 0, 14, 10};
    tbl[8] = '{1, 11, 5, 0, 2};

    rst = 1'b1; start = '0; v_in = '0; m_in = '0;
    repeat (3) step();
    rst = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("reset_busy%0d", d), busy[d], 1'b0);
      chk($sformatf("reset_done%0d", d), done[d], 1'b0);
      chk($sformatf("reset_v_o%0d", d), vo[d], '0);
    end
    step();

    // RFC 7693 "abc" block with cycle-accurate busy/done.
    for (int i = 0; i < 16; i++) v_in[W*i +: W] = ABC_V[i];
    m_in = '0;
    m_in[31:0] = 32'h00636261;
    v_start = v_in;
    exp = ref_comp(v_in, m_in, 80);
    start_dut(0);
    for (int c = 1; c <= 161; c++) begin
      chk($sformatf("abc_busy_c%0d", c), busy[0], (c <= 160) ? 1'b1 : 1'b0);
      chk($sformatf("abc_done_c%0d", c), done[0], (c == 161) ? 1'b1 : 1'b0);
      if (c < 161) step();
    end
    chk("abc_v_o_model", vo[0], exp);
    for (int i = 0; i < 8; i++)
      chk($sformatf("abc_hash_w%0d", i),
          v_start[W*i +: W] ^ vo[0][W*i +: W] ^ vo[0][W*(i+8) +: W], ABC_H[i]);
    step();
    chk("abc_after_done", done[0], 1'b0);

    // Operand-select vector table with m word i = i.
    for (int t = 0; t < 9; t++) begin
      int d, k;
      d = tbl[t].d;
      for (int i = 0; i < 16; i++) m_in[W*i +: W] = i;
      v_in = rnd_vec();
      k = 8 * tbl[t].r + tbl[t].j;
      tgt = 1 + 2 * k;
      vm = ref_comp(v_in, m_in, k);
      start_dut(d);
      for (int c = 1; c < tgt; c++) step();
      chk($sformatf("probe%0d_x", t), gx_o[d], tbl[t].ex);
      chk($sformatf("probe%0d_y", t), gy_o[d], tbl[t].ey);
      chk($sformatf("probe%0d_a", t), ga_o[d], vm[W*IA[tbl[t].j] +: W]);
      chk($sformatf("probe%0d_b", t), gb_o[d], vm[W*IB[tbl[t].j] +: W]);
      chk($sformatf("probe%0d_c", t), gc_o[d], vm[W*IC[tbl[t].j] +: W]);
      chk($sformatf("probe%0d_d", t), gd_o[d], vm[W*ID[tbl[t].j] +: W]);
      chk($sformatf("probe%0d_busy", t), busy[d], 1'b1);
      wait_done(d, cyc);
      step();
    end

    // Randomized full compressions on every instance.
    for (int n = 0; n < 4; n++) begin
      v_in = rnd_vec(); m_in = rnd_vec();
      run_to_done(0, $sformatf("rand10_%0d", n));
    end
    for (int n = 0; n < 2; n++) begin
      v_in = rnd_vec(); m_in = rnd_vec();
      run_to_done(1, $sformatf("rand12_%0d", n));
    end
    for (int n = 0; n < 3; n++) begin
      v_in = rnd_vec(); m_in = rnd_vec();
      run_to_done(2, $sformatf("rand1_%0d", n));
    end

    // start pulses while busy and on the done cycle are dropped.
    v_in = rnd_vec(); m_in = rnd_vec();
    exp = ref_comp(v_in, m_in, 80);
    start_dut(0);
    v_in = rnd_vec(); m_in = rnd_vec();
    nd = 0; dc = 0;
    for (int c = 1; c <= 400; c++) begin
      start[0] = (c == 40 || c == 161);
      if (done[0]) begin nd++; dc = c; end
      step();
    end
    start[0] = 1'b0;
    chk("ignore_start_done_count", nd, 1);
    chk("ignore_start_done_cycle", dc, 161);
    chk("ignore_start_v_o", vo[0], exp);
    chk("ignore_start_busy", busy[0], 1'b0);

    // Reset in cycle 50 aborts the compression.
    v_in = rnd_vec(); m_in = rnd_vec();
    start_dut(0);
    for (int c = 1; c < 50; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", busy[0], 1'b0);
    chk("midrst_v_o", vo[0], '0);
    chk("midrst_done", done[0], 1'b0);
    nd = 0;
    for (int c = 0; c < 300; c++) begin
      if (done[0] || busy[0]) nd++;
      step();
    end
    chk("midrst_quiet", nd, 0);
    v_in = rnd_vec(); m_in = rnd_vec();
    run_to_done(0, "after_rst");

    // ROUNDS=1 with an all-zero state stays zero.
    v_in = '0; m_in = '0;
    start_dut(2);
    wait_done(2, cyc);
    chk("r1_zero_done_cycle", cyc, 17);
    chk("r1_zero_v_o", vo[2], '0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/blake2_g_sched.md
BLAKE2_G_SCHED -- requirements
Module: blake2_g_sched

Interface
REQ-001 SHALL have parameter W, default 32, meaning word width in bits (32 = BLAKE2s, 64 = BLAKE2b).
REQ-002 SHALL have parameter ROUNDS, default 10, meaning number of rounds; legal range 1..12.
REQ-003 SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start_i  input  1  request compression; sampled only in IDLE.
REQ-007 SHALL have port v_i  input  16*W  initial working vector; word i at bits [W*i+W-1:W*i].
REQ-008 SHALL have port m_i  input  16*W  message block; same packing as v_i.
REQ-009 SHALL have port busy_o  output  1  high while calls are in flight.
REQ-010 SHALL have port done_o  output  1  one-cycle pulse; v_o valid.
REQ-011 SHALL have port v_o  output  16*W  final working vector; same packing as v_i.
REQ-012 SHALL have ports g_a_o, g_b_o, g_c_o, g_d_o, g_x_o, g_y_o  output  W each  operands to the external G mixer.
REQ-013 SHALL have ports g_a_i, g_b_i, g_c_i, g_d_i  input  W each  G mixer results.

Function
REQ-014 SHALL drive the external G mixer as its initiator; G registers operands on the issue-cycle edge, and results are valid combinationally during the following cycle.
REQ-015 SHALL implement FSM states IDLE, ISSUE, WB, DONE.
REQ-016 In IDLE with start_i=1, SHALL load v_i and m_i into internal registers, clear the round counter r and call counter j, and go to ISSUE.
REQ-017 In ISSUE, SHALL go to WB.
REQ-018 In WB, SHALL write g_a_i, g_b_i, g_c_i, g_d_i back to working-vector words a, b, c, d of call j, then advance: j=7 -> j=0, r+1; r=ROUNDS-1 and j=7 -> DONE, otherwise -> ISSUE.
REQ-019 In DONE, SHALL assert done_o for exactly that cycle and go to IDLE.
REQ-020 SHALL use these index sets for call j (a,b,c,d): j0 (0,4,8,12), j1 (1,5,9,13), j2 (2,6,10,14), j3 (3,7,11,15), j4 (0,5,10,15), j5 (1,6,11,12), j6 (2,7,8,13), j7 (3,4,9,14).
REQ-021 SHALL drive g_x_o = m[SIGMA[r mod 10][2j]] and g_y_o = m[SIGMA[r mod 10][2j+1]], using the RFC 7693 SIGMA table.
REQ-022 SHALL drive g_a_o..g_d_o combinationally from the current working vector and j in every state; the values are meaningful only in ISSUE.
REQ-023 SHALL issue calls serially, one call every 2 cycles; if start is accepted at edge 0, call k (0..8*ROUNDS-1) issues in cycle 1+2k and writes back in cycle 2+2k.
REQ-024 SHALL assert done_o in cycle 1+16*ROUNDS (161 for the default).
REQ-025 SHALL hold busy_o = 1 in ISSUE and WB, and 0 in IDLE and DONE.
REQ-026 SHALL make v_o equal the working-vector register, updated only in WB; v_o SHALL hold after DONE until the next accepted start.
REQ-027 SHALL ignore start_i in ISSUE, WB and DONE, with no queuing; a start that coincides with done_o is dropped.
REQ-028 SHALL ignore changes on v_i and m_i after the load edge.

Reset
REQ-029 When rst=1 at a clock edge, SHALL enter IDLE and clear r, j, the working-vector register, the message register, busy_o, done_o and v_o to 0.
REQ-030 SHALL give rst priority over start_i and over any in-flight call, including a WB cycle; no writeback occurs on a reset edge.
REQ-031 After reset mid-operation, SHALL not assert done_o until a new start_i is accepted.

Verification
REQ-032 SHALL cover: RFC 7693 Appendix B BLAKE2s "abc" initial v, m word0=0x00636261 and others 0 -> v_o matches the Appendix B final v, so that h' = 508C5E8C...86675982.
REQ-033 SHALL cover: m_i word i = i -> call 0 of round 0 has g_x_o=0, g_y_o=1; call 0 of round 1 has g_x_o=14, g_y_o=10; call 0 of round 10 (ROUNDS=12) has g_x_o=0, g_y_o=1.
REQ-034 SHALL cover: start at edge 0 -> busy_o=1 in cycles 1..160, done_o=1 only in cycle 161, busy_o=0 in cycle 161.
REQ-035 SHALL cover: start_i pulsed in cycles 40 and 161 -> no effect, exactly one done_o, and v_o unchanged after cycle 161.
REQ-036 SHALL cover: rst in cycle 50 -> IDLE next cycle with busy_o=0 and v_o=0; no done_o; a subsequent start completes normally.
REQ-037 SHALL cover: ROUNDS=1 with v_i=0 and m_i=0 -> done_o in cycle 17, v_o=0.
